// File: rtl/copperv_lsu.sv
// copperv load/store unit: turns one execute-stage memory request into a
// data-bus read or write transaction and returns extended load data or status.
package copperv_lsu_pkg;
  typedef enum logic [2:0] {
    mem_byte   = 3'd0,
    mem_hword  = 3'd1,
    mem_word   = 3'd2,
    mem_byteu  = 3'd4,
    mem_hwordu = 3'd5
  } funct_e;

  typedef enum logic {
    ok   = 1'b0,
    fail = 1'b1
  } data_write_resp_e;
endpackage

module copperv_lsu
  import copperv_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  funct_e                req_funct,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic                  dr_addr_valid,
  input  logic                  dr_addr_ready,
  output logic [ADDR_WIDTH-1:0] dr_addr,
  input  logic                  dr_data_valid,
  output logic                  dr_data_ready,
  input  logic [31:0]           dr_data,
  output logic                  dw_valid,
  input  logic                  dw_ready,
  output logic [ADDR_WIDTH-1:0] dw_addr,
  output logic [31:0]           dw_data,
  output logic [3:0]            dw_strobe,
  input  logic                  dw_resp_valid,
  output logic                  dw_resp_ready,
  input  data_write_resp_e      dw_resp
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_e;

  state_e                state_q, state_d;
  funct_e                funct_q, funct_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  req_ready_q, req_ready_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [31:0]           resp_rdata_q, resp_rdata_d;
  logic                  resp_error_q, resp_error_d;
  logic                  dr_addr_valid_q, dr_addr_valid_d;
  logic [ADDR_WIDTH-1:0] dr_addr_q, dr_addr_d;
  logic                  dr_data_ready_q, dr_data_ready_d;
  logic                  dw_valid_q, dw_valid_d;
  logic [ADDR_WIDTH-1:0] dw_addr_q, dw_addr_d;
  logic [31:0]           dw_data_q, dw_data_d;
  logic [3:0]            dw_strobe_q, dw_strobe_d;
  logic                  dw_resp_ready_q, dw_resp_ready_d;
  logic [ADDR_WIDTH-1:0] word_addr_s;

  function automatic logic is_illegal(input funct_e f, input logic st, input logic [1:0] a);
    logic bad;
    case (f)
      mem_byte:   bad = 1'b0;
      mem_hword:  bad = MISALIGN_CHECK && a[0];
      mem_word:   bad = MISALIGN_CHECK && (a != 2'b00);
      mem_byteu:  bad = st;
      mem_hwordu: bad = st || (MISALIGN_CHECK && a[0]);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  // Lane select follows the access size, so with the check off the low bits drop out.
  function automatic logic [31:0] load_extend(input funct_e f, input logic [1:0] a,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{a, 3'b000} +: 8];
    h = word[{a[1], 4'b0000} +: 16];
    case (f)
      mem_byte:   r = {{24{b[7]}}, b};
      mem_hword:  r = {{16{h[15]}}, h};
      mem_word:   r = word;
      mem_byteu:  r = {24'd0, b};
      mem_hwordu: r = {16'd0, h};
      default:    r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic [35:0] store_lanes(input funct_e f, input logic [1:0] a,
                                              input logic [31:0] w);
    logic [35:0] r;
    case (f)
      mem_byte:  r = {{4{w[7:0]}}, 4'b0001 << a};
      mem_hword: r = {{2{w[15:0]}}, 4'b0011 << {a[1], 1'b0}};
      mem_word:  r = {w, 4'b1111};
      default:   r = 36'd0;
    endcase
    return r;
  endfunction

  assign word_addr_s = {req_addr[ADDR_WIDTH-1:2], 2'b00};

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d         = state_q;
    funct_d         = funct_q;
    addr_lo_d       = addr_lo_q;
    req_ready_d     = req_ready_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = 32'd0;
    resp_error_d    = 1'b0;
    dr_addr_valid_d = dr_addr_valid_q;
    dr_addr_d       = dr_addr_q;
    dr_data_ready_d = dr_data_ready_q;
    dw_valid_d      = dw_valid_q;
    dw_addr_d       = dw_addr_q;
    dw_data_d       = dw_data_q;
    dw_strobe_d     = dw_strobe_q;
    dw_resp_ready_d = dw_resp_ready_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          funct_d     = req_funct;
          addr_lo_d   = req_addr[1:0];
          req_ready_d = 1'b0;
          if (is_illegal(req_funct, req_store, req_addr[1:0])) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else if (req_store) begin
            state_d                  = WR_REQ;
            dw_valid_d               = 1'b1;
            dw_addr_d                = word_addr_s;
            {dw_data_d, dw_strobe_d} = store_lanes(req_funct, req_addr[1:0], req_wdata);
          end else begin
            state_d         = RD_ADDR;
            dr_addr_valid_d = 1'b1;
            dr_addr_d       = word_addr_s;
          end
        end else begin
          req_ready_d = 1'b1;
        end
      end
      RD_ADDR: begin
        if (dr_addr_ready) begin
          state_d         = RD_DATA;
          dr_addr_valid_d = 1'b0;
          dr_data_ready_d = 1'b1;
        end else begin
          state_d = RD_ADDR;
        end
      end
      RD_DATA: begin
        if (dr_data_valid) begin
          state_d         = RESP;
          dr_data_ready_d = 1'b0;
          resp_valid_d    = 1'b1;
          resp_rdata_d    = load_extend(funct_q, addr_lo_q, dr_data);
        end else begin
          state_d = RD_DATA;
        end
      end
      WR_REQ: begin
        if (dw_ready) begin
          state_d         = WR_RESP;
          dw_valid_d      = 1'b0;
          dw_resp_ready_d = 1'b1;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_RESP: begin
        if (dw_resp_valid) begin
          state_d         = RESP;
          dw_resp_ready_d = 1'b0;
          resp_valid_d    = 1'b1;
          resp_error_d    = (dw_resp == fail);
        end else begin
          state_d = WR_RESP;
        end
      end
      RESP: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d         = IDLE;
        req_ready_d     = 1'b1;
        dr_addr_valid_d = 1'b0;
        dr_data_ready_d = 1'b0;
        dw_valid_d      = 1'b0;
        dw_resp_ready_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      funct_q         <= mem_byte;
      addr_lo_q       <= 2'd0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'd0;
      resp_error_q    <= 1'b0;
      dr_addr_valid_q <= 1'b0;
      dr_addr_q       <= '0;
      dr_data_ready_q <= 1'b0;
      dw_valid_q      <= 1'b0;
      dw_addr_q       <= '0;
      dw_data_q       <= 32'd0;
      dw_strobe_q     <= 4'd0;
      dw_resp_ready_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      funct_q         <= funct_d;
      addr_lo_q       <= addr_lo_d;
      req_ready_q     <= req_ready_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_error_q    <= resp_error_d;
      dr_addr_valid_q <= dr_addr_valid_d;
      dr_addr_q       <= dr_addr_d;
      dr_data_ready_q <= dr_data_ready_d;
      dw_valid_q      <= dw_valid_d;
      dw_addr_q       <= dw_addr_d;
      dw_data_q       <= dw_data_d;
      dw_strobe_q     <= dw_strobe_d;
      dw_resp_ready_q <= dw_resp_ready_d;
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_error    = resp_error_q;
  assign dr_addr_valid = dr_addr_valid_q;
  assign dr_addr       = dr_addr_q;
  assign dr_data_ready = dr_data_ready_q;
  assign dw_valid      = dw_valid_q;
  assign dw_addr       = dw_addr_q;
  assign dw_data       = dw_data_q;
  assign dw_strobe     = dw_strobe_q;
  assign dw_resp_ready = dw_resp_ready_q;

endmodule

// File: tb/tb_copperv_lsu.sv
// Randomized bench for copperv_lsu: a byte-level reference model predicts every
// bus request and response; a negedge monitor compares the DUT against it.
module tb_copperv_lsu;
  import copperv_lsu_pkg::*;

  localparam int K_NONE = 0, K_ERR = 1, K_LOAD = 2, K_STORE = 3;

  logic clk = 1'b0;
  logic rst;
  logic req_valid, req_ready, req_store;
  funct_e req_funct;
  logic [31:0] req_addr, req_wdata;
  logic resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic dr_addr_valid, dr_addr_ready, dr_data_valid, dr_data_ready;
  logic [31:0] dr_addr, dr_data;
  logic dw_valid, dw_ready, dw_resp_valid, dw_resp_ready;
  logic [31:0] dw_addr, dw_data;
  logic [3:0] dw_strobe;
  data_write_resp_e dw_resp;

  int total = 0;
  int bad = 0;

  int exp_kind = K_NONE;
  int exp_lat;
  logic exp_err;
  logic [31:0] exp_rdata, exp_waddr, exp_wdata;
  logic [3:0] exp_strb;

  logic [31:0] cap_rdata, cap_dr_addr, cap_dw_data;
  logic [3:0] cap_strb;
  logic cap_err, cap_bus;
  int cap_lat;

  always #5 clk = ~clk;

  copperv_lsu #(.ADDR_WIDTH(32), .MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct(req_funct), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .dr_addr_valid(dr_addr_valid), .dr_addr_ready(dr_addr_ready), .dr_addr(dr_addr),
    .dr_data_valid(dr_data_valid), .dr_data_ready(dr_data_ready), .dr_data(dr_data),
    .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr), .dw_data(dw_data),
    .dw_strobe(dw_strobe), .dw_resp_valid(dw_resp_valid), .dw_resp_ready(dw_resp_ready),
    .dw_resp(dw_resp)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int nbytes_of(input funct_e f);
    case (f)
      mem_byte, mem_byteu:   return 1;
      mem_hword, mem_hwordu: return 2;
      mem_word:              return 4;
      default:               return 0;
    endcase
  endfunction

  function automatic bit is_unsigned(input funct_e f);
    return (f == mem_byteu) || (f == mem_hwordu);
  endfunction

  // Reference model: size in bytes, alignment by modulo, extension by arithmetic.
  task automatic set_model(input bit st, input funct_e f, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword, input bit wfail,
                           input int ad, input int dd, input int wdl, input int rdl);
    int n, off;
    bit illegal;
    longint v, lim;
    n = nbytes_of(f);
    off = int'(addr % 32'd4);
    exp_waddr = addr & 32'hFFFF_FFFC;
    exp_rdata = 32'd0;
    exp_wdata = 32'd0;
    exp_strb = 4'd0;
    exp_err = 1'b0;
    if (n == 0) illegal = 1'b1;
    else illegal = (st && is_unsigned(f)) || (off % n != 0);
    if (illegal) begin
      exp_kind = K_ERR;
      exp_err = 1'b1;
      exp_lat = 1;
    end else if (!st) begin
      lim = longint'(1) << (8 * n);
      v = longint'(rword >> (8 * off)) % lim;
      if (!is_unsigned(f) && v >= lim / 2) v = v - lim;
      exp_rdata = v[31:0];
      exp_kind = K_LOAD;
      exp_lat = 3 + ad + dd;
    end else begin
      for (int k = 0; k < 4; k++) begin
        exp_wdata[8*k +: 8] = wdata[8*(k % n) +: 8];
        exp_strb[k] = (k >= off) && (k < off + n);
      end
      exp_err = wfail;
      exp_kind = K_STORE;
      exp_lat = 3 + wdl + rdl;
    end
  endtask

  // Monitor: every cycle, any bus request or response must match the model.
  always @(negedge clk) begin
    if (!rst && exp_kind != K_NONE) begin
      if (dr_addr_valid) begin
        check("dr_addr_valid_allowed", 32'(exp_kind == K_LOAD), 32'd1);
        check("dr_addr", dr_addr, exp_waddr);
      end
      if (dw_valid) begin
        check("dw_valid_allowed", 32'(exp_kind == K_STORE), 32'd1);
        check("dw_addr", dw_addr, exp_waddr);
        check("dw_data", dw_data, exp_wdata);
        check("dw_strobe", 32'(dw_strobe), 32'(exp_strb));
      end
      if (resp_valid) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_error", 32'(resp_error), 32'(exp_err));
        check("req_ready_in_resp", 32'(req_ready), 32'd0);
      end
    end
  end

  task automatic clear_slave();
    dr_addr_ready = 1'b0;
    dr_data_valid = 1'b0;
    dr_data = 32'd0;
    dw_ready = 1'b0;
    dw_resp_valid = 1'b0;
    dw_resp = ok;
  endtask

  task automatic check_reset_state();
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_dr_addr_valid", 32'(dr_addr_valid), 32'd0);
    check("rst_dr_addr", dr_addr, 32'd0);
    check("rst_dr_data_ready", 32'(dr_data_ready), 32'd0);
    check("rst_dw_valid", 32'(dw_valid), 32'd0);
    check("rst_dw_addr", dw_addr, 32'd0);
    check("rst_dw_data", dw_data, 32'd0);
    check("rst_dw_strobe", 32'(dw_strobe), 32'd0);
    check("rst_dw_resp_ready", 32'(dw_resp_ready), 32'd0);
  endtask

  // One transaction: issue the request, then act as a bus slave with the given delays.
  task automatic run_txn(input bit st, input funct_e f, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rword, input bit wfail,
                         input int ad, input int dd, input int wdl, input int rdl);
    int ca, cd, cw, cr;
    bit done;
    set_model(st, f, addr, wdata, rword, wfail, ad, dd, wdl, rdl);
    ca = 0; cd = 0; cw = 0; cr = 0; done = 1'b0;
    cap_bus = 1'b0; cap_lat = 0; cap_rdata = 32'hDEAD_BEEF; cap_err = 1'b0;
    cap_dr_addr = 32'd0; cap_dw_data = 32'd0; cap_strb = 4'd0;
    @(negedge clk);
    check("req_ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_store = st; req_funct = f; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_store = $urandom_range(0, 1);
    req_funct = funct_e'(3'($urandom_range(0, 7)));
    req_addr = $urandom;
    req_wdata = $urandom;
    for (int c = 1; c <= 300 && !done; c++) begin
      @(negedge clk);
      if (dr_addr_valid) begin
        if (!cap_bus) cap_dr_addr = dr_addr;
        cap_bus = 1'b1;
        dr_addr_ready = (ca >= ad);
        ca++;
      end else dr_addr_ready = 1'b0;
      if (dr_data_ready) begin
        dr_data_valid = (cd >= dd);
        dr_data = dr_data_valid ? rword : $urandom;
        cd++;
      end else begin
        dr_data_valid = 1'($urandom_range(0, 1));
        dr_data = $urandom;
      end
      if (dw_valid) begin
        if (!cap_bus) begin cap_dw_data = dw_data; cap_strb = dw_strobe; end
        cap_bus = 1'b1;
        dw_ready = (cw >= wdl);
        cw++;
      end else dw_ready = 1'b0;
      if (dw_resp_ready) begin
        dw_resp_valid = (cr >= rdl);
        dw_resp = dw_resp_valid ? (wfail ? fail : ok) : data_write_resp_e'($urandom_range(0, 1));
        cr++;
      end else begin
        dw_resp_valid = 1'($urandom_range(0, 1));
        dw_resp = data_write_resp_e'($urandom_range(0, 1));
      end
      if (resp_valid) begin
        done = 1'b1;
        cap_lat = c;
        cap_rdata = resp_rdata;
        cap_err = resp_error;
      end
    end
    clear_slave();
    check("resp_seen", 32'(done), 32'd1);
    check("latency", cap_lat, exp_lat);
    @(negedge clk);
    check("resp_one_cycle", 32'(resp_valid), 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
    exp_kind = K_NONE;
  endtask

  task automatic reset_mid_load();
    int seen;
    set_model(1'b0, mem_byte, 32'h0000_7001, 32'd0, 32'd0, 1'b0, 0, 0, 0, 0);
    seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_store = 1'b0; req_funct = mem_byte; req_addr = 32'h0000_7001;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 50 && seen == 0; c++) begin
      @(negedge clk);
      dr_addr_ready = dr_addr_valid;
      dr_data_valid = 1'b0;
      if (dr_data_ready) seen = 1;
    end
    check("reached_rd_data", seen, 32'd1);
    clear_slave();
    exp_kind = K_NONE;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;
  endtask

  funct_e legal_f[5] = '{mem_byte, mem_hword, mem_word, mem_byteu, mem_hwordu};

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_store = 1'b0; req_funct = mem_byte; req_addr = 32'd0; req_wdata = 32'd0;
    clear_slave();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state();
    rst = 1'b0;

    run_txn(1'b0, mem_byte, 32'h0000_1003, 32'd0, 32'h80FF_1234, 1'b0, 0, 0, 0, 0);
    check("lit_lb_rdata", cap_rdata, 32'hFFFF_FF80);
    check("lit_lb_addr", cap_dr_addr, 32'h0000_1000);
    check("lit_lb_lat", cap_lat, 32'd3);

    run_txn(1'b0, mem_hwordu, 32'h0000_2002, 32'd0, 32'h9ABC_5678, 1'b0, 4, 0, 0, 0);
    check("lit_lhu_rdata", cap_rdata, 32'h0000_9ABC);
    check("lit_lhu_addr", cap_dr_addr, 32'h0000_2000);

    run_txn(1'b1, mem_byte, 32'h0000_3001, 32'h0000_00AB, 32'd0, 1'b0, 0, 0, 0, 0);
    check("lit_sb_data", cap_dw_data, 32'hABAB_ABAB);
    check("lit_sb_strb", 32'(cap_strb), 32'h2);
    check("lit_sb_err", 32'(cap_err), 32'd0);
    check("lit_sb_lat", cap_lat, 32'd3);

    run_txn(1'b1, mem_word, 32'h0000_4000, 32'h1357_9BDF, 32'd0, 1'b1, 0, 0, 0, 3);
    check("lit_sw_strb", 32'(cap_strb), 32'hF);
    check("lit_sw_err", 32'(cap_err), 32'd1);

    run_txn(1'b0, mem_word, 32'h0000_5002, 32'd0, 32'h1111_2222, 1'b0, 0, 0, 0, 0);
    check("lit_mis_err", 32'(cap_err), 32'd1);
    check("lit_mis_rdata", cap_rdata, 32'd0);
    check("lit_mis_lat", cap_lat, 32'd1);
    check("lit_mis_nobus", 32'(cap_bus), 32'd0);

    run_txn(1'b1, mem_hwordu, 32'h0000_0010, 32'hFFFF_FFFF, 32'd0, 1'b0, 0, 0, 0, 0);
    check("lit_shu_err", 32'(cap_err), 32'd1);
    check("lit_shu_nobus", 32'(cap_bus), 32'd0);
    check("lit_shu_lat", cap_lat, 32'd1);

    reset_mid_load();
    run_txn(1'b0, mem_byte, 32'h0000_0010, 32'd0, 32'h1234_56F7, 1'b0, 0, 0, 0, 0);
    check("lit_post_rst_rdata", cap_rdata, 32'hFFFF_FFF7);
    check("lit_post_rst_err", 32'(cap_err), 32'd0);

    for (int i = 0; i < 200; i++) begin
      funct_e f;
      logic [31:0] a;
      if ($urandom_range(0, 4) != 0) f = legal_f[$urandom_range(0, 4)];
      else f = funct_e'(3'($urandom_range(0, 7)));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_txn(1'($urandom_range(0, 1)), f, a, $urandom, $urandom, 1'($urandom_range(0, 1)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/copperv_lsu.md
Name: copperv_lsu

Overview:
- Load/store unit sitting between the copperv execute stage and the data bus.
- Accepts one memory request per transaction from the control unit in the `mem` state. The request carries `funct_e` width codes `mem_byte`, `mem_hword`, `mem_word`, `mem_byteu` and `mem_hwordu`.
- Drives the data-read and data-write channels with valid/ready handshakes.
- Returns aligned, sign- or zero-extended load data, or store completion, feeding the `mem` path of the rd write-back mux.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- MISALIGN_CHECK, 1, 1 = misaligned requests complete with error and no bus access; 0 = low address bits ignored for hword/word.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct  in  funct_e  width/sign code
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and errors)
- resp_error  out  1  misaligned, illegal funct, or write resp `fail`
- dr_addr_valid  out  1  read address valid
- dr_addr_ready  in  1  read address accepted
- dr_addr  out  ADDR_WIDTH  word-aligned read address
- dr_data_valid  in  1  read data valid
- dr_data_ready  out  1  LSU accepts read data
- dr_data  in  32  read word
- dw_valid  out  1  write address+data valid
- dw_ready  in  1  write accepted
- dw_addr  out  ADDR_WIDTH  word-aligned write address
- dw_data  out  32  lane-replicated write data
- dw_strobe  out  4  byte enables
- dw_resp_valid  in  1  write response valid
- dw_resp_ready  out  1  LSU accepts response
- dw_resp  in  data_write_resp_e  `ok`/`fail`

Behaviour:
- **Reset (rst=1 at posedge):**
  - State goes to IDLE.
  - All valid/ready outputs are 0, except req_ready=1 after reset.
  - Address, data and strobe outputs are 0; resp_rdata=0, resp_error=0.
  - Reset mid-transaction abandons the bus transfer; the bus slave is reset together with the LSU.
- **States:** IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- **IDLE:**
  - req_ready=1. On req_valid, latch req_*.
  - Illegal request (checked first): funct not one of the five mem codes, or a store with byteu/hwordu, or (MISALIGN_CHECK=1 and misaligned) → RESP with error=1.
  - Misaligned means hword with addr[0]=1, or word with addr[1:0]≠0.
  - Otherwise a load → RD_ADDR, a store → WR_REQ.
- **RD_ADDR:**
  - dr_addr_valid=1, dr_addr={addr[ADDR_WIDTH-1:2],2'b00}, held stable until dr_addr_ready.
  - On dr_addr_ready → RD_DATA.
- **RD_DATA:**
  - dr_data_ready=1. On dr_data_valid, extract lane and extend, then → RESP with error=0.
  - byte = dr_data[8*a+7:8*a] where a=addr[1:0].
  - hword = dr_data[16*addr[1]+15:16*addr[1]].
  - mem_byte/mem_hword sign-extend; mem_byteu/mem_hwordu zero-extend.
  - dr_data_valid outside RD_DATA is ignored.
- **WR_REQ:**
  - dw_valid=1 with dw_addr word-aligned; outputs held until dw_ready, then → WR_RESP.
  - byte: dw_data={4{wdata[7:0]}}, dw_strobe=4'b0001<<addr[1:0].
  - hword: dw_data={2{wdata[15:0]}}, dw_strobe=4'b0011<<{addr[1],1'b0}.
  - word: dw_data=wdata, dw_strobe=4'b1111.
- **WR_RESP:** dw_resp_ready=1. On dw_resp_valid, error=(dw_resp==fail), then → RESP.
- **RESP:** resp_valid=1 for exactly one cycle with rdata/error, then → IDLE.
- **Latency:**
  - Zero-wait load: accept at cycle N, addr handshake N+1, data N+2, resp_valid N+3.
  - Zero-wait store: resp_valid at N+3.
  - Error response: resp_valid at N+1.
- **Throughput and handshakes:**
  - Minimum one idle cycle between transactions (req_ready=0 during RESP).
  - Ready signals may be held low indefinitely; no timeout.
  - Valid outputs never drop before their handshake completes.
- **Registered outputs:** all outputs are registered or decoded from state only; no combinational path from bus inputs to bus outputs.

Test Plan:
- Load mem_byte addr 0x1003, dr_data 0x80FF_1234, zero wait → dr_addr 0x1000, resp_rdata 0xFFFF_FF80, resp_valid 3 cycles after accept.
- Load mem_hwordu addr 0x2002, dr_data 0x9ABC_5678, dr_addr_ready delayed 4 cycles → dr_addr stable throughout, resp_rdata 0x0000_9ABC.
- Store mem_byte addr 0x3001, wdata 0x0000_00AB, dw_resp ok → dw_data 0xABAB_ABAB, dw_strobe 4'b0010, resp_error 0.
- Store mem_word addr 0x4000, dw_resp fail after 3-cycle delay → dw_strobe 4'b1111, resp_valid with resp_error 1.
- Load mem_word addr 0x5002 (MISALIGN_CHECK=1), and store with mem_hwordu → no dr_addr_valid/dw_valid, resp_valid next cycle, resp_error 1, resp_rdata 0.
- rst asserted during RD_DATA, then new byte load addr 0x10 → all outputs 0 after reset, req_ready 1, new transaction completes normally.
